// File: rtl/int_status_queue.sv
// Consumer end of the interrupt-status stream: masks each beat, queues accepted
// beats in a small FIFO, presents the head entry and drives a level interrupt.
module int_status_queue #(
  parameter int NUM_INT_BDS_WIDTH = 2,
  parameter int FIFO_DEPTH        = 4,
  parameter int FIFO_DEPTH_WIDTH  = 2
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         valid,
  input  logic                         opDone,
  input  logic                         wrError,
  input  logic                         rdError,
  input  logic                         dscrptrNValidError,
  input  logic [NUM_INT_BDS_WIDTH-1:0] intDscrptrNum,
  input  logic                         extDscrptr,
  input  logic [31:0]                  extDscrptrAddr,
  input  logic                         strDscrptr,
  input  logic [3:0]                   mask,
  input  logic                         popReq,
  input  logic                         ovfClr,
  output logic                         irq,
  output logic                         headValid,
  output logic [3:0]                   headStatus,
  output logic [NUM_INT_BDS_WIDTH-1:0] headIntDscrptrNum,
  output logic                         headExtDscrptr,
  output logic [31:0]                  headExtDscrptrAddr,
  output logic                         headStrDscrptr,
  output logic [FIFO_DEPTH_WIDTH:0]    fifoCount,
  output logic                         overflow
);

  localparam int ENTRY_W = 4 + NUM_INT_BDS_WIDTH + 1 + 32 + 1;
  localparam logic [FIFO_DEPTH_WIDTH:0] DEPTH_C = (FIFO_DEPTH_WIDTH + 1)'(FIFO_DEPTH);

  logic [ENTRY_W-1:0]          mem [FIFO_DEPTH];
  logic [FIFO_DEPTH_WIDTH-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [FIFO_DEPTH_WIDTH:0]   count_reg, count_next;
  logic                        overflow_reg, overflow_next;
  logic                        irq_reg;

  logic [3:0]         status;
  logic [ENTRY_W-1:0] wr_entry, head_entry;
  logic               acc, empty, full, push, pop, drop;

  assign status   = {dscrptrNValidError, rdError, wrError, opDone};
  assign acc      = valid & |(status & mask);
  assign empty    = (count_reg == '0);
  assign full     = (count_reg == DEPTH_C);
  // A full FIFO still takes the beat when the head is popped in the same cycle.
  assign push     = acc & (~full | popReq);
  assign pop      = popReq & ~empty;
  assign drop     = acc & full & ~popReq;
  assign wr_entry = {status, intDscrptrNum, extDscrptr, extDscrptrAddr, strDscrptr};

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // A drop in the same cycle as ovfClr keeps the flag set.
  always_comb begin
    overflow_next = overflow_reg;
    if (drop)
      overflow_next = 1'b1;
    else if (ovfClr)
      overflow_next = 1'b0;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      irq_reg      <= 1'b0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
      irq_reg      <= (count_next != '0) | overflow_next;
    end
  end

  // Storage carries no reset; emptiness gating below hides stale contents.
  always_ff @(posedge clock) begin
    if (push)
      mem[wr_ptr_reg] <= wr_entry;
  end

  assign head_entry = empty ? '0 : mem[rd_ptr_reg];

  assign headValid          = ~empty;
  assign headStatus         = head_entry[ENTRY_W-1 -: 4];
  assign headIntDscrptrNum  = head_entry[ENTRY_W-5 -: NUM_INT_BDS_WIDTH];
  assign headExtDscrptr     = head_entry[33];
  assign headExtDscrptrAddr = head_entry[32:1];
  assign headStrDscrptr     = head_entry[0];
  assign fifoCount          = count_reg;
  assign overflow           = overflow_reg;
  assign irq                = irq_reg;

endmodule

// File: tb/tb_int_status_queue.sv
// Randomized and directed bench for int_status_queue against a queue-based
// reference model of the accept/drop/pop rules.
module tb_int_status_queue;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        valid = 1'b0, opDone = 1'b0, wrError = 1'b0, rdError = 1'b0;
  logic        dscrptrNValidError = 1'b0;
  logic [1:0]  intDscrptrNum = '0;
  logic        extDscrptr = 1'b0;
  logic [31:0] extDscrptrAddr = '0;
  logic        strDscrptr = 1'b0;
  logic [3:0]  mask = '0;
  logic        popReq = 1'b0, ovfClr = 1'b0;
  logic        irq, headValid, headExtDscrptr, headStrDscrptr, overflow;
  logic [3:0]  headStatus;
  logic [1:0]  headIntDscrptrNum;
  logic [31:0] headExtDscrptrAddr;
  logic [2:0]  fifoCount;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0]  st;
    logic [1:0]  num;
    logic        ext;
    logic [31:0] addr;
    logic        str;
  } ent_t;

  ent_t q[$];
  logic m_ovf = 1'b0;

  int_status_queue #(.NUM_INT_BDS_WIDTH(2), .FIFO_DEPTH(4), .FIFO_DEPTH_WIDTH(2)) dut (
    .clock(clock), .resetn(resetn), .valid(valid), .opDone(opDone),
    .wrError(wrError), .rdError(rdError), .dscrptrNValidError(dscrptrNValidError),
    .intDscrptrNum(intDscrptrNum), .extDscrptr(extDscrptr),
    .extDscrptrAddr(extDscrptrAddr), .strDscrptr(strDscrptr), .mask(mask),
    .popReq(popReq), .ovfClr(ovfClr), .irq(irq), .headValid(headValid),
    .headStatus(headStatus), .headIntDscrptrNum(headIntDscrptrNum),
    .headExtDscrptr(headExtDscrptr), .headExtDscrptrAddr(headExtDscrptrAddr),
    .headStrDscrptr(headStrDscrptr), .fifoCount(fifoCount), .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    ent_t h;
    h = '{st: 4'h0, num: 2'h0, ext: 1'b0, addr: 32'h0, str: 1'b0};
    if (q.size() > 0) h = q[0];
    chk({tag, ".headValid"}, 64'(headValid), 64'(q.size() > 0));
    chk({tag, ".headStatus"}, 64'(headStatus), 64'(h.st));
    chk({tag, ".headNum"}, 64'(headIntDscrptrNum), 64'(h.num));
    chk({tag, ".headExt"}, 64'(headExtDscrptr), 64'(h.ext));
    chk({tag, ".headAddr"}, 64'(headExtDscrptrAddr), 64'(h.addr));
    chk({tag, ".headStr"}, 64'(headStrDscrptr), 64'(h.str));
    chk({tag, ".fifoCount"}, 64'(fifoCount), 64'(q.size()));
    chk({tag, ".overflow"}, 64'(overflow), 64'(m_ovf));
    chk({tag, ".irq"}, 64'(irq), 64'((q.size() != 0) || m_ovf));
  endtask

  // One clock of stimulus, then the model applies the same beat and outputs are compared.
  task automatic step(input string tag, input logic v, input logic [3:0] st,
                      input logic [1:0] num, input logic ext, input logic [31:0] addr,
                      input logic str, input logic [3:0] msk, input logic pop,
                      input logic clr);
    logic acc, accept, drop;
    valid = v; {dscrptrNValidError, rdError, wrError, opDone} = st;
    intDscrptrNum = num; extDscrptr = ext; extDscrptrAddr = addr; strDscrptr = str;
    mask = msk; popReq = pop; ovfClr = clr;
    @(posedge clock);
    acc    = v && ((st & msk) != 4'h0);
    accept = acc && (q.size() < 4 || pop);
    drop   = acc && !accept;
    if (pop && q.size() > 0) void'(q.pop_front());
    if (accept) q.push_back('{st: st, num: num, ext: ext, addr: addr, str: str});
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    #1;
    $display("%s: v=%0b st=%h mask=%h pop=%0b clr=%0b acc=%0b drop=%0b count=%0d ovf=%0b",
             tag, v, st, msk, pop, clr, accept, drop, q.size(), m_ovf);
    compare_all(tag);
  endtask

  task automatic idle(input string tag, input logic pop, input logic clr);
    step(tag, 1'b0, 4'h0, 2'h0, 1'b0, 32'h0, 1'b0, 4'hF, pop, clr);
  endtask

  initial begin
    #12;
    compare_all("reset");
    resetn = 1'b1;

    // Single accepted opDone beat.
    step("t1_beat", 1'b1, 4'b0001, 2'h1, 1'b1, 32'h1000_0040, 1'b0, 4'b0001, 1'b0, 1'b0);
    chk("t1_status", 64'(headStatus), 64'h1);
    chk("t1_addr", 64'(headExtDscrptrAddr), 64'h1000_0040);
    chk("t1_count", 64'(fifoCount), 64'd1);
    idle("t1_idle", 1'b0, 1'b0);
    chk("t1_irq", 64'(irq), 64'd1);
    idle("t1_pop", 1'b1, 1'b0);

    // Masked-off beat is silently discarded.
    step("t2_masked", 1'b1, 4'b0001, 2'h0, 1'b0, 32'h2, 1'b0, 4'b0110, 1'b0, 1'b0);
    chk("t2_count", 64'(fifoCount), 64'd0);
    chk("t2_irq", 64'(irq), 64'd0);
    chk("t2_ovf", 64'(overflow), 64'd0);

    // Five wrError beats into a depth-4 FIFO.
    for (int i = 0; i < 5; i++)
      step("t3_fill", 1'b1, 4'b0010, 2'(i), i[0], 32'h3000_0000 + i, 1'b1, 4'hF, 1'b0, 1'b0);
    chk("t3_count", 64'(fifoCount), 64'd4);
    chk("t3_ovf", 64'(overflow), 64'd1);
    for (int i = 0; i < 4; i++) idle("t3_pop", 1'b1, 1'b0);
    chk("t3_empty", 64'(headValid), 64'd0);
    idle("t3_clr", 1'b0, 1'b1);

    // Full FIFO with an accepted beat and popReq together.
    for (int i = 0; i < 4; i++)
      step("t4_fill", 1'b1, 4'b0100, 2'(i), 1'b0, 32'h4000_0000 + i, 1'b0, 4'hF, 1'b0, 1'b0);
    step("t4_swap", 1'b1, 4'b1000, 2'h3, 1'b1, 32'h4000_00FF, 1'b1, 4'hF, 1'b1, 1'b0);
    chk("t4_count", 64'(fifoCount), 64'd4);
    chk("t4_ovf", 64'(overflow), 64'd0);
    chk("t4_head", 64'(headExtDscrptrAddr), 64'h4000_0001);

    // Drain, then an extra pop on empty.
    for (int i = 0; i < 4; i++) idle("t5_pop", 1'b1, 1'b0);
    chk("t5_irq", 64'(irq), 64'd0);
    idle("t5_extra", 1'b1, 1'b0);
    chk("t5_count", 64'(fifoCount), 64'd0);

    // Overflow set beats a coincident clear.
    for (int i = 0; i < 5; i++)
      step("t6_fill", 1'b1, 4'b0001, 2'(i), 1'b0, 32'h6000_0000 + i, 1'b0, 4'hF, 1'b0, 1'b0);
    step("t6_setwins", 1'b1, 4'b0001, 2'h0, 1'b0, 32'h6000_00AA, 1'b0, 4'hF, 1'b0, 1'b1);
    chk("t6_ovf_kept", 64'(overflow), 64'd1);
    idle("t6_clr", 1'b0, 1'b1);
    chk("t6_ovf_clr", 64'(overflow), 64'd0);
    chk("t6_irq", 64'(irq), 64'd1);
    for (int i = 0; i < 4; i++) idle("t6_drain", 1'b1, 1'b0);

    // Randomized traffic with one asynchronous reset mid-stream.
    for (int i = 0; i < 300; i++) begin
      logic [3:0] msk;
      msk = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
      step("rnd", $urandom_range(0, 3) != 0, 4'($urandom), 2'($urandom), 1'($urandom),
           $urandom, 1'($urandom), msk, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
      if (i == 150) begin
        resetn = 1'b0;
        #1;
        q.delete();
        m_ovf = 1'b0;
        compare_all("arst");
        #1 resetn = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
